// File: rtl/mem_bridge_pkg.sv
// Shared types for the load/store memory bridge: FSM state encoding,
// load/store width codes and the access legality rule.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_bridge_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // A request is legal when its width code exists for its direction and
  // the byte address is naturally aligned for that width.
  function automatic logic access_legal(input logic       is_write,
                                        input logic [2:0] f3,
                                        input logic [1:0] offset);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~offset[0];
      3'b010:  ok = (offset == 2'b00);
      3'b100:  ok = ~is_write;
      3'b101:  ok = ~is_write & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Memory-side bus of the bridge. The bridge is the master; the memory
// (or a testbench model) is the slave.
interface mem_bridge_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_bridge_align.sv
// mem_align: purely combinational byte-lane logic. Computes store byte
// enables and lane-shifted store data, and extracts/extends load data.
module mem_align
  import rv32i_types::*;
(
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel   = mem_rdata[{offset, 3'b000} +: 8];
  assign half_sel   = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign wdata_lane = wdata << {offset, 3'b000};

  // Byte enables: reads always fetch the whole word.
  always_comb begin
    byte_enable = 4'b1111;
    if (is_write) begin
      case (store_funct3_t'(funct3))
        SB:      byte_enable = 4'b0001 << offset;
        SH:      byte_enable = 4'b0011 << offset;
        default: byte_enable = 4'b1111;
      endcase
    end
  end

  // Load extraction with sign or zero extension by width code.
  always_comb begin
    load_data = mem_rdata;
    case (load_funct3_t'(funct3))
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding CPU load/store to memory bridge.
// Optional build macro MEM_BRIDGE_TIMEOUT_EN adds an ACCESS watchdog that
// fails the access after TIMEOUT_CYCLES cycles without mem_resp.
//
// state  | meaning
// IDLE   | waiting for req_read/req_write
// ACCESS | strobe held on the memory bus until mem_resp (or timeout)
// DONE   | one-cycle resp (plus error on failure), rdata valid
module mem_bridge
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               resp,
  output logic               busy,
  output logic               error,
  mem_bridge_if.master       mem
);

  mem_bridge_state_t state, state_n;

  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        is_write_q;
  logic        err_q;

  logic        req_any;
  logic        req_is_write;
  logic        req_legal;
  logic        strobe;
  logic        to_hit;

  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] load_data;

  // A simultaneous read and write request is treated as a read.
  assign req_any      = req_read | req_write;
  assign req_is_write = ~req_read & req_write;
  assign req_legal    = access_legal(req_is_write, funct3, addr[1:0]);

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_bridge: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;

  // Watchdog down-counter: reloaded outside ACCESS, terminal count at zero
  // marks the last allowed ACCESS cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != ACCESS) begin
      to_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign to_hit = (state == ACCESS) && (to_cnt == '0);
`else
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and FSM-decoded outputs.
  always_comb begin
    state_n = state;
    strobe  = 1'b0;
    resp    = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_any) state_n = req_legal ? ACCESS : DONE;
      end
      ACCESS: begin
        strobe = 1'b1;
        if (mem.mem_resp || to_hit) state_n = DONE;
      end
      DONE: begin
        resp    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture and result registers; a real mem_resp beats a
  // coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        addr_q     <= addr;
        funct3_q   <= funct3;
        wdata_q    <= wdata;
        is_write_q <= req_is_write;
        err_q      <= ~req_legal;
        if (!req_legal) rdata <= '0;
      end
      if (state == ACCESS) begin
        if (mem.mem_resp) begin
          rdata <= is_write_q ? 32'h0 : load_data;
          err_q <= 1'b0;
        end else if (to_hit) begin
          rdata <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end

  mem_align u_align (
    .is_write    (is_write_q),
    .funct3      (funct3_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .mem_rdata   (mem.mem_rdata),
    .byte_enable (be_lane),
    .wdata_lane  (wdata_lane),
    .load_data   (load_data)
  );

  assign error               = (state == DONE) & err_q;
  assign mem.mem_read        = strobe & ~is_write_q;
  assign mem.mem_write       = strobe & is_write_q;
  assign mem.mem_address     = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata       = wdata_lane;
  assign mem.mem_byte_enable = strobe ? be_lane : 4'b0000;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases, busy-time request
// blocking, mid-access reset, watchdog behaviour and randomized traffic
// against a spec-level reference model.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;
  logic        busy;
  logic        error;

  mem_bridge_if mif();

  mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .resp      (resp),
    .busy      (busy),
    .error     (error),
    .mem       (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations from the last do_op call.
  int          o_lat;
  logic        o_err;
  logic [31:0] o_rdata;
  int          o_nstb;
  logic        o_saw_rd;
  logic        o_saw_wr;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wd;
  logic        o_stable;

  function automatic bit ref_legal(input bit is_rd, input logic [2:0] f3,
                                   input logic [31:0] a);
    int unsigned size;
    size = 1 << f3[1:0];
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (!is_rd && f3 > 3'd2) return 1'b0;
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] mr);
    logic [31:0] sh;
    sh = mr >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return mr;
    endcase
  endfunction

  // Issue one request, play memory with a response after dly strobe cycles,
  // and record what the bus and CPU side showed.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] mr, input int dly);
    int waited;
    waited = 0;
    @(negedge clk);
    req_read  = rd;
    req_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mif.mem_resp  = 1'($urandom_range(0, 1));
    mif.mem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_read  = 1'b0;
    req_write = 1'b0;
    funct3    = 3'($urandom_range(0, 7));
    addr      = $urandom;
    wdata     = $urandom;
    o_lat = -1; o_err = 1'b0; o_rdata = 32'hX; o_nstb = 0;
    o_saw_rd = 1'b0; o_saw_wr = 1'b0; o_stable = 1'b1;
    o_addr = '0; o_be = '0; o_wd = '0;
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) @(negedge clk);
      mif.mem_resp = 1'b0;
      if (resp) begin
        o_lat   = n;
        o_err   = error;
        o_rdata = rdata;
        mif.mem_resp = 1'b1;
        break;
      end
      if (mif.mem_read || mif.mem_write) begin
        if (o_nstb == 0) begin
          o_addr = mif.mem_address;
          o_be   = mif.mem_byte_enable;
          o_wd   = mif.mem_wdata;
        end else if (o_addr !== mif.mem_address || o_be !== mif.mem_byte_enable ||
                     o_wd !== mif.mem_wdata) begin
          o_stable = 1'b0;
        end
        if (mif.mem_read)  o_saw_rd = 1'b1;
        if (mif.mem_write) o_saw_wr = 1'b1;
        o_nstb++;
        if (waited == dly) begin
          mif.mem_resp  = 1'b1;
          mif.mem_rdata = mr;
        end else begin
          mif.mem_rdata = $urandom;
        end
        waited++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || resp !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b resp=%b error=%b want 000", busy, resp, error);
    end
    checks++; if (mif.mem_read !== 1'b0 || mif.mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: rd=%b wr=%b want 00", mif.mem_read, mif.mem_write);
    end
    checks++; if (rdata !== 32'h0 || mif.mem_address !== 32'h0 || mif.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", rdata, mif.mem_address, mif.mem_wdata);
    end
    checks++; if (mif.mem_byte_enable !== 4'h0) begin
      errors++; $display("FAIL reset_be: got %b want 0000", mif.mem_byte_enable);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checks++; if (o_lat !== 2 || o_err !== 1'b0) begin
      errors++; $display("FAIL lw_latency: lat=%0d err=%b want 2/0", o_lat, o_err);
    end
    checks++; if (o_nstb !== 1 || o_saw_rd !== 1'b1 || o_addr !== 32'h100) begin
      errors++; $display("FAIL lw_bus: strobes=%0d rd=%b addr=%h want 1/1/100", o_nstb, o_saw_rd, o_addr);
    end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata);
    end
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    checks++; if (o_rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata);
    end
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    checks++; if (o_rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_rdata: got %h want 00000080", o_rdata);
    end
    do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 2);
    checks++; if (o_rdata !== 32'h000080FF) begin
      errors++; $display("FAIL lhu_rdata: got %h want 000080ff", o_rdata);
    end
    do_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 0);
    checks++; if (o_be !== 4'b0010 || o_wd !== 32'h0000AB00 || o_addr !== 32'h200) begin
      errors++; $display("FAIL sb_bus: be=%b wdata=%h addr=%h want 0010/0000ab00/200", o_be, o_wd, o_addr);
    end
    checks++; if (o_saw_wr !== 1'b1 || o_saw_rd !== 1'b0 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL sb_result: wr=%b rd=%b rdata=%h want 1/0/0", o_saw_wr, o_saw_rd, o_rdata);
    end
    do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0);
    checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_nstb !== 0) begin
      errors++; $display("FAIL lw_misaligned: lat=%0d err=%b strobes=%0d want 1/1/0", o_lat, o_err, o_nstb);
    end
  endtask

  task automatic test_busy_ignore();
    logic ok;
    logic got;
    ok  = 1'b1;
    got = 1'b0;
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    mif.mem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b1; funct3 = 3'b000; addr = 32'h445; wdata = $urandom;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge clk);
      mif.mem_resp = 1'b0;
      if (resp) begin got = 1'b1; break; end
      if (mif.mem_read !== 1'b1 || mif.mem_write !== 1'b0 ||
          mif.mem_address !== 32'h300 || mif.mem_byte_enable !== 4'hF) ok = 1'b0;
      if (n == 3) begin mif.mem_resp = 1'b1; mif.mem_rdata = 32'hCAFEF00D; end
    end
    req_write = 1'b0;
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL busy_hold: bus changed while busy, got %b want 1", ok);
    end
    checks++; if (got !== 1'b1 || rdata !== 32'hCAFEF00D || error !== 1'b0) begin
      errors++; $display("FAIL busy_result: resp=%b rdata=%h error=%b want 1/cafef00d/0", got, rdata, error);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    logic strobe_seen;
    @(negedge clk);
    mif.mem_resp = 1'b0;
    req_read = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h104;
    @(posedge clk);
    @(negedge clk);
    req_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    strobe_seen = mif.mem_read;
    checks++; if (strobe_seen !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: mem_read=%b want 1", strobe_seen);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (mif.mem_read !== 1'b0 || busy !== 1'b0 || mif.mem_byte_enable !== 4'h0) begin
      errors++; $display("FAIL midrst_async: rd=%b busy=%b be=%b want 0/0/0000", mif.mem_read, busy, mif.mem_byte_enable);
    end
    @(negedge clk);
    checks++; if (resp !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL midrst_hold: resp=%b rdata=%h want 0/0", resp, rdata);
    end
    mif.mem_resp = 1'b1;
    req_read = 1'b1; funct3 = 3'b010; addr = 32'h108;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_read = 1'b0;
    checks++; if (resp !== 1'b0 || busy !== 1'b1 || mif.mem_read !== 1'b1 || mif.mem_address !== 32'h108) begin
      errors++; $display("FAIL midrst_accept: resp=%b busy=%b rd=%b addr=%h want 0/1/1/108", resp, busy, mif.mem_read, mif.mem_address);
    end
    mif.mem_resp  = 1'b1;
    mif.mem_rdata = 32'h12345678;
    @(negedge clk);
    mif.mem_resp = 1'b0;
    checks++; if (resp !== 1'b1 || rdata !== 32'h12345678) begin
      errors++; $display("FAIL midrst_done: resp=%b rdata=%h want 1/12345678", resp, rdata);
    end
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h5A5A5A5A, 0);
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h11111111, 1000);
    checks++; if (o_lat !== TO + 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL timeout_resp: lat=%0d err=%b want %0d/1", o_lat, o_err, TO + 1);
    end
    checks++; if (o_nstb !== TO || o_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_bus: strobes=%0d rdata=%h want %0d/0", o_nstb, o_rdata, TO);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 40);
    checks++; if (o_lat !== 42 || o_err !== 1'b0) begin
      errors++; $display("FAIL slow_resp: lat=%0d err=%b want 42/0", o_lat, o_err);
    end
    checks++; if (o_nstb !== 41 || o_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL slow_bus: strobes=%0d rdata=%h want 41/0badf00d", o_nstb, o_rdata);
    end
  endtask
`endif

  task automatic test_random();
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, mr, exp_rdata, exp_wd;
    logic [3:0]  exp_be;
    int          dly, exp_lat, be_int;
    bit          legal;
    for (int i = 0; i < 40; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd  = $urandom;
      mr  = $urandom;
      dly = $urandom_range(0, 3);
      do_op(rd, wr, f3, a, wd, mr, dly);
      legal     = ref_legal(rd, f3, a);
      exp_lat   = legal ? 2 + dly : 1;
      exp_rdata = (legal && rd) ? ref_load(f3, a, mr) : 32'h0;
      be_int    = ((1 << (1 << f3[1:0])) - 1) << a[1:0];
      exp_be    = rd ? 4'hF : be_int[3:0];
      exp_wd    = wd << (8 * a[1:0]);
      checks++; if (o_lat !== exp_lat || o_err !== !legal) begin
        errors++; $display("FAIL rnd_resp[%0d]: lat=%0d err=%b want %0d/%b", i, o_lat, o_err, exp_lat, !legal);
      end
      checks++; if (o_rdata !== exp_rdata) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h (f3=%0d a=%h)", i, o_rdata, exp_rdata, f3, a);
      end
      if (legal) begin
        checks++; if (o_nstb !== dly + 1 || o_saw_rd !== rd || o_saw_wr !== !rd || o_stable !== 1'b1) begin
          errors++; $display("FAIL rnd_strobe[%0d]: n=%0d rd=%b wr=%b stable=%b want %0d/%b/%b/1", i, o_nstb, o_saw_rd, o_saw_wr, o_stable, dly + 1, rd, !rd);
        end
        checks++; if (o_addr !== {a[31:2], 2'b00} || o_be !== exp_be) begin
          errors++; $display("FAIL rnd_addr_be[%0d]: addr=%h be=%b want %h/%b", i, o_addr, o_be, {a[31:2], 2'b00}, exp_be);
        end
        if (!rd) begin
          checks++; if (o_wd !== exp_wd) begin
            errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o_wd, exp_wd);
          end
        end
      end else begin
        checks++; if (o_nstb !== 0) begin
          errors++; $display("FAIL rnd_reject[%0d]: strobes=%0d want 0", i, o_nstb);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; req_read = 1'b0; req_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mif.mem_resp = 1'b0; mif.mem_rdata = 32'h0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_mid_reset();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles in ACCESS awaiting mem_resp (used only with MEM_BRIDGE_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_read  in  1  CPU load request.
- req_write  in  1  CPU store request.
- funct3  in  3  load/store width code.
- addr  in  32  byte address from MAR.
- wdata  in  32  store data from mem_wdata register.
- rdata  out  32  aligned, extended load data to MDR.
- resp  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- error  out  1  one-cycle pulse coincident with resp on a failed access.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-shifted store data.
- mem_byte_enable  out  4  byte lanes.
- mem_rdata  in  32  memory read data.
- mem_resp  in  1  memory completion.

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; IDLE -> DONE directly on a rejected request.
REQ-004 SHALL, in IDLE, accept when req_read|req_write; register addr, funct3, wdata, direction; both high -> read wins, write dropped.
REQ-005 SHALL ignore requests while busy=1.
REQ-006 SHALL reject (-> DONE, error=1, no strobe) halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 not in {000,001,010,100,101}; stores with 100/101 are illegal.
REQ-007 SHALL hold mem_read or mem_write high for every ACCESS cycle, mem_address/mem_wdata/mem_byte_enable stable, until mem_resp=1.
REQ-008 SHALL, on mem_resp in ACCESS, register load result into rdata and move to DONE; strobes low from next cycle.
REQ-009 SHALL assert resp for exactly the DONE cycle; latency accept edge -> resp = 2 cycles with same-cycle mem_resp.
REQ-010 SHALL hold rdata from DONE until the next load completes; stores and errors write rdata=0.
REQ-011 SHALL drive mem_byte_enable: read 4'b1111; SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-012 SHALL drive mem_wdata = wdata << (8*addr[1:0]).
REQ-013 SHALL extract loads: LB/LBU byte at addr[1:0] sign/zero-extended; LH/LHU halfword at addr[1] sign/zero-extended; LW unchanged.
REQ-014 SHALL ignore mem_resp outside ACCESS.

Reset
REQ-015 SHALL, on rst=0, immediately (asynchronously) force IDLE; resp, busy, error, mem_read, mem_write = 0; rdata, mem_address, mem_wdata = 0; mem_byte_enable = 0.
REQ-016 SHALL abandon an in-flight access on mid-operation reset with no resp; first accept possible on the first clk edge after rst rises.

Configuration
REQ-017 SHALL, with MEM_BRIDGE_TIMEOUT_EN defined, count ACCESS cycles; on reaching TIMEOUT_CYCLES without mem_resp drop strobes, go DONE, error=1, rdata=0; counter clears on entering ACCESS.
REQ-018 SHALL, without MEM_BRIDGE_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely; error arises only per REQ-006.

Structure
REQ-019 SHALL place mem_bridge_state_t (IDLE/ACCESS/DONE) and load_funct3_t/store_funct3_t enums in package rv32i_types.
REQ-020 SHALL factor lane logic (REQ-011..013) into combinational sub-module mem_align.

Verification
REQ-021 LW addr=0x100, mem_rdata=0xDEADBEEF, mem_resp same cycle -> mem_read 1 cycle, mem_address=0x100, resp 2 cycles after accept, rdata=0xDEADBEEF.
REQ-022 LB addr=0x103, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
REQ-023 SB addr=0x201, wdata=0x000000AB -> mem_byte_enable=4'b0010, mem_wdata=0x0000AB00, mem_address=0x200, rdata=0.
REQ-024 LW addr=0x102 -> no mem_read, resp=1 and error=1 one cycle after accept.
REQ-025 mem_resp delayed 5 cycles; rst=0 pulsed on cycle 3 -> strobes drop asynchronously, no resp; with MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_resp -> error=1 with resp after 4 ACCESS cycles.
